ray_dispatcher: RTL and testbench
=================================

# ray_dispatcher

Frame-level ray source that sits directly upstream of the quad ray unit. On a frame request it flushes the ray units, then walks every pixel of a width×height frame in raster order. For each pixel it forms the camera ray (shared origin, incrementally stepped direction) and the pixel's framebuffer address, and issues it on the ray unit's start/ready handshake. After the last pixel has been accepted and the ray units go idle, it reports frame completion.

## Interface
- POSITION_WIDTH, 16, width of each ray vector component
- ADDRESS_WIDTH, 32, framebuffer address width
- X_BITS, 10, pixel column counter width
- Y_BITS, 10, pixel row counter width
- clock  in  1  single system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- frameStart  in  1  one-cycle pulse requesting a frame; ignored unless idle
- width  in  X_BITS  pixels per row, sampled at frameStart
- height  in  Y_BITS  rows per frame, sampled at frameStart
- cameraQ  in  POSITION_WIDTH×[2:0]  ray origin, sampled at frameStart
- cornerV  in  POSITION_WIDTH×[2:0]  direction of pixel (0,0), sampled at frameStart
- stepX  in  POSITION_WIDTH×[2:0]  direction increment per column, sampled at frameStart
- stepY  in  POSITION_WIDTH×[2:0]  direction increment per row, sampled at frameStart
- frameBase  in  ADDRESS_WIDTH  address of pixel (0,0), sampled at frameStart
- unitReady  in  1  ray unit can accept a ray this cycle
- unitBusy  in  1  any ray unit still working
- flush  out  1  one-cycle flush to ray units
- start  out  1  ray issue strobe; asserted only when unitReady is high
- rayQ  out  POSITION_WIDTH×[2:0]  current ray origin
- rayV  out  POSITION_WIDTH×[2:0]  current ray direction
- pixelAddress  out  ADDRESS_WIDTH  current pixel address
- frameBusy  out  1  high from the cycle after an accepted frameStart until frameDone
- frameDone  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, FLUSH, ISSUE, DRAIN, DONE.
- IDLE: frameStart=1 latches all frame inputs and loads x=0, y=0, rowV=cornerV, rayV=cornerV, pixelAddress=frameBase. Next state is FLUSH.
- FLUSH: flush=1 for exactly one cycle. If width==0 or height==0, go to DRAIN. Otherwise go to ISSUE.
- ISSUE: start = unitReady (combinational AND with state==ISSUE). rayQ, rayV and pixelAddress are registered and stable while start is low.
- On start=1 with x<width-1: x+=1, rayV+=stepX, pixelAddress+=1.
- On start=1 with x==width-1 and y<height-1: x=0, y+=1, rowV+=stepY, rayV=rowV+stepY, pixelAddress+=1.
- On start=1 at the last pixel (x==width-1, y==height-1): go to DRAIN. The outputs hold their values.
- DRAIN: wait a minimum of 2 cycles, which covers the ray unit's busy lag. Then go to DONE on the first cycle with unitBusy==0.
- DONE: frameDone=1 for one cycle, then IDLE.
- Arithmetic: vector components wrap modulo 2^POSITION_WIDTH, with no saturation. pixelAddress wraps modulo 2^ADDRESS_WIDTH. One address per pixel.
- rayQ equals the latched cameraQ for the whole frame.
- frameStart outside IDLE is ignored, with no effect on latched values.
- Input changes after frameStart do not affect the frame in progress.

## Timing
- Reset: state=IDLE; flush, start, frameBusy and frameDone = 0; rayQ, rayV, pixelAddress, x, y = 0.
- Reset mid-frame aborts immediately. No further start is issued, and frameDone is not pulsed.
- frameStart in cycle 0: flush=1 and frameBusy=1 in cycle 1; ISSUE from cycle 2, so the first start can occur in cycle 2.
- Throughput: one ray per cycle while unitReady stays high. Updated outputs are visible the cycle after each start.
- Total starts per frame = width×height exactly.
- Completion: frameDone occurs no earlier than 3 cycles after the last start. frameBusy falls in the cycle after frameDone.
- unitReady toggling: start tracks it combinationally. No ray is skipped or duplicated.

## Test plan
- Frame 2×2 setup: width=2, height=2, cornerV=(0,0,0), stepX=(1,0,0), stepY=(0,1,0), frameBase=0x100, unitReady=1.
  - Required response: 4 consecutive starts with rayV=(0,0,0),(1,0,0),(0,1,0),(1,1,0) and pixelAddress=0x100..0x103.
  - Required response: flush one cycle before the first start; frameDone after unitBusy falls.
- 3×1 frame with unitReady low every other cycle -> exactly 3 starts, each coinciding with unitReady=1; rayV/pixelAddress held between starts.
- width=0 -> flush pulse, zero starts, frameDone within 4 cycles of frameStart.
- stepX=(0xFFFF,0,0), cornerV=(0,0,0), width=3 -> rayV.x = 0x0000, 0xFFFF, 0xFFFE (wrap).
- Hold unitBusy=1 for 20 cycles after the last start -> frameDone not asserted until the cycle after unitBusy drops (plus DRAIN minimum). A second frameStart during this period is ignored.
- reset asserted after 5 of 16 starts -> next cycle all outputs 0 and state IDLE. No frameDone. A new frameStart runs a full frame correctly.

Source files
------------

// File: rtl/ray_dispatcher.sv
// Frame-level ray source: flushes the ray units, walks a width x height frame in raster
// order issuing one camera ray per pixel, then waits for the units to drain.
module ray_dispatcher #(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int X_BITS         = 10,
    parameter int Y_BITS         = 10
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                frameStart_i,
    input  logic [X_BITS-1:0]                   width_i,
    input  logic [Y_BITS-1:0]                   height_i,
    input  logic [2:0][POSITION_WIDTH-1:0]      cameraQ_i,
    input  logic [2:0][POSITION_WIDTH-1:0]      cornerV_i,
    input  logic [2:0][POSITION_WIDTH-1:0]      stepX_i,
    input  logic [2:0][POSITION_WIDTH-1:0]      stepY_i,
    input  logic [ADDRESS_WIDTH-1:0]            frameBase_i,
    input  logic                                unitReady_i,
    input  logic                                unitBusy_i,
    output logic                                flush_o,
    output logic                                start_o,
    output logic [2:0][POSITION_WIDTH-1:0]      rayQ_o,
    output logic [2:0][POSITION_WIDTH-1:0]      rayV_o,
    output logic [ADDRESS_WIDTH-1:0]            pixelAddress_o,
    output logic                                frameBusy_o,
    output logic                                frameDone_o
);

    typedef logic [2:0][POSITION_WIDTH-1:0] vec_t;
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [X_BITS-1:0]     width_q, x_q;
    logic [Y_BITS-1:0]     height_q, y_q;
    vec_t                  rayq_q, rayv_q, rowv_q, stepx_q, stepy_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                  drain_q;
    logic                  fire, last_col, last_row, empty_frame;

    function automatic vec_t vadd(input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < 3; i++) r[i] = a[i] + b[i];
        return r;
    endfunction

    assign fire        = (state_q == S_ISSUE) && unitReady_i;
    assign last_col    = (x_q == width_q - X_BITS'(1));
    assign last_row    = (y_q == height_q - Y_BITS'(1));
    assign empty_frame = (width_q == '0) || (height_q == '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frameStart_i) state_d = S_FLUSH;
            S_FLUSH: state_d = empty_frame ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (fire && last_col && last_row) state_d = S_DRAIN;
            S_DRAIN: if (!drain_q && !unitBusy_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked by reset so an abort never leaks a start in the reset cycle.
    always_comb begin
        flush_o     = 1'b0;
        start_o     = 1'b0;
        frameDone_o = 1'b0;
        frameBusy_o = (state_q != S_IDLE);
        if (!reset_i) begin
            flush_o     = (state_q == S_FLUSH);
            start_o     = fire;
            frameDone_o = (state_q == S_DONE);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rayq_q   <= '0;
            rayv_q   <= '0;
            rowv_q   <= '0;
            stepx_q  <= '0;
            stepy_q  <= '0;
            addr_q   <= '0;
            drain_q  <= 1'b1;
        end else begin
            // Down-count of the minimum drain dwell; reloaded whenever outside DRAIN.
            drain_q <= (state_q != S_DRAIN);
            case (state_q)
                S_IDLE: begin
                    if (frameStart_i) begin
                        width_q  <= width_i;
                        height_q <= height_i;
                        rayq_q   <= cameraQ_i;
                        stepx_q  <= stepX_i;
                        stepy_q  <= stepY_i;
                        rowv_q   <= cornerV_i;
                        rayv_q   <= cornerV_i;
                        addr_q   <= frameBase_i;
                        x_q      <= '0;
                        y_q      <= '0;
                    end
                end
                S_ISSUE: begin
                    if (fire) begin
                        if (!last_col) begin
                            x_q    <= x_q + X_BITS'(1);
                            rayv_q <= vadd(rayv_q, stepx_q);
                            addr_q <= addr_q + ADDRESS_WIDTH'(1);
                        end else if (!last_row) begin
                            x_q    <= '0;
                            y_q    <= y_q + Y_BITS'(1);
                            rowv_q <= vadd(rowv_q, stepy_q);
                            rayv_q <= vadd(rowv_q, stepy_q);
                            addr_q <= addr_q + ADDRESS_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rayQ_o         = rayq_q;
    assign rayV_o         = rayv_q;
    assign pixelAddress_o = addr_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher against a closed-form raster model.
module tb_ray_dispatcher;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int XB = 10;
    localparam int YB = 10;
    typedef logic [2:0][PW-1:0] vec_t;

    logic          clk = 1'b0, rst = 1'b1, fs = 1'b0, rdy = 1'b0, ubusy = 1'b0;
    logic [XB-1:0] w_in = '0;
    logic [YB-1:0] h_in = '0;
    vec_t          camq = '0, corner = '0, sx = '0, sy = '0;
    logic [AW-1:0] base = '0;
    logic          flush, start, fbusy, fdone;
    vec_t          rq, rv;
    logic [AW-1:0] pa;

    ray_dispatcher #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .X_BITS(XB), .Y_BITS(YB)) dut (
        .clock_i(clk), .reset_i(rst), .frameStart_i(fs), .width_i(w_in), .height_i(h_in),
        .cameraQ_i(camq), .cornerV_i(corner), .stepX_i(sx), .stepY_i(sy), .frameBase_i(base),
        .unitReady_i(rdy), .unitBusy_i(ubusy), .flush_o(flush), .start_o(start),
        .rayQ_o(rq), .rayV_o(rv), .pixelAddress_o(pa), .frameBusy_o(fbusy), .frameDone_o(fdone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vec_t          got_v[$];
    vec_t          got_q[$];
    logic [AW-1:0] got_a[$];
    int            start_cyc[$];
    int flush_first, flush_cnt, done_cyc, done_cnt, noready_starts, hold_err;
    int busy_gap, busy_at0, busy_at1, busy_after_done, timed_out, rst_snap_ok, post_rst_starts;

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < 3; i++) r[i] = PW'($urandom());
        return r;
    endfunction

    // Ray direction of pixel (x,y): corner + x*stepX + y*stepY, modulo 2^PW.
    function automatic vec_t model_v(input vec_t c, input vec_t a, input vec_t b, input int x, input int y);
        vec_t r;
        for (int i = 0; i < 3; i++) r[i] = c[i] + PW'(x) * a[i] + PW'(y) * b[i];
        return r;
    endfunction

    function automatic logic [AW-1:0] model_a(input logic [AW-1:0] b, input int w, input int x, input int y);
        return b + AW'(y * w + x);
    endfunction

    // Earliest legal frameDone given the last start and how long unitBusy stays high after it.
    function automatic int model_done(input int last, input int hold);
        return last + ((hold + 1 > 2) ? hold + 1 : 2) + 1;
    endfunction

    // Drives one frame and records what the DUT did; comparisons live in the test tasks.
    task automatic run_frame(input int w, input int h, input logic [AW-1:0] b, input vec_t cq,
                             input vec_t cv, input vec_t stx, input vec_t sty, input int rmode,
                             input int hold, input int rst_after, input bit restart, input int max_cyc);
        int c, total, last, n, rst_cyc;
        got_v.delete(); got_q.delete(); got_a.delete(); start_cyc.delete();
        flush_first = -1; flush_cnt = 0; done_cyc = -1; done_cnt = 0; noready_starts = 0;
        hold_err = 0; busy_gap = 0; busy_after_done = -1; timed_out = 0; rst_snap_ok = 0;
        post_rst_starts = 0;
        total = w * h; last = -1; n = 0; rst_cyc = -1;
        @(posedge clk); #1;
        fs = 1'b1; w_in = XB'(w); h_in = YB'(h); base = b; camq = cq; corner = cv; sx = stx; sy = sty;
        rdy = (rmode == 0); ubusy = 1'b0;
        @(negedge clk);
        busy_at0 = fbusy;
        c = 1;
        while (1) begin
            @(posedge clk); #1;
            fs = restart && total > 0 && n == total && c == last + 5;
            if (c == 1 || fs) begin
                w_in = XB'($urandom_range(1, 7)); h_in = YB'($urandom_range(1, 7));
                camq = rand_vec(); corner = rand_vec(); sx = rand_vec(); sy = rand_vec();
                base = $urandom();
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ubusy = (n > 0) && !(n == total && c > last + hold) && (rst_cyc < 0);
            rst = (rst_after >= 0 && n == rst_after && rst_cyc < 0);
            if (rst) rst_cyc = c;
            @(negedge clk);
            if (c == 1) busy_at1 = fbusy;
            if (rst_cyc >= 0 && c == rst_cyc + 1)
                rst_snap_ok = (!flush && !start && !fbusy && !fdone && rq == '0 && rv == '0 && pa == '0);
            if (flush) begin
                flush_cnt++;
                if (flush_first < 0) flush_first = c;
            end
            if (start) begin
                if (!rdy) noready_starts++;
                if (rst_cyc >= 0) post_rst_starts++;
                else begin
                    got_v.push_back(rv); got_q.push_back(rq); got_a.push_back(pa);
                    start_cyc.push_back(c); n++; last = c;
                end
            end else if (fbusy && !rst && rst_cyc < 0 && n < total) begin
                if (rv !== model_v(cv, stx, sty, n % w, n / w) || pa !== model_a(b, w, n % w, n / w))
                    hold_err++;
            end
            if (fdone) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after_done = fbusy;
            if (done_cyc < 0 && rst_cyc < 0 && !fbusy) busy_gap++;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            if (rst_cyc >= 0 && c >= rst_cyc + 6) break;
            if (c >= max_cyc) begin
                timed_out = 1;
                break;
            end
            c++;
        end
        @(posedge clk); #1;
        fs = 1'b0; rst = 1'b0; rdy = 1'b0; ubusy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; fs = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({flush, start, fdone} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000", {flush, start, fdone});
        end
        @(posedge clk); #1;
        rst = 1'b0; fs = 1'b0;
        @(negedge clk);
        checks++;
        if ({flush, start, fbusy, fdone} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {flush, start, fbusy, fdone});
        end
        checks++;
        if (rq !== '0 || rv !== '0 || pa !== '0) begin
            errors++; $display("FAIL reset_data: got rayQ=%h rayV=%h addr=%h expected zeros", rq, rv, pa);
        end
        rdy = 1'b0;
    endtask

    task automatic test_frame_2x2();
        vec_t cq, exp_v[4];
        cq = rand_vec();
        exp_v[0] = {16'd0, 16'd0, 16'd0}; exp_v[1] = {16'd0, 16'd0, 16'd1};
        exp_v[2] = {16'd0, 16'd1, 16'd0}; exp_v[3] = {16'd0, 16'd1, 16'd1};
        run_frame(2, 2, 32'h100, cq, '0, {16'd0, 16'd0, 16'd1}, {16'd0, 16'd1, 16'd0}, 0, 2, -1, 0, 200);
        checks++;
        if (got_v.size() != 4) begin
            errors++; $display("FAIL f2x2_count: got %0d starts expected 4", got_v.size());
        end
        for (int i = 0; i < got_v.size() && i < 4; i++) begin
            checks++;
            if (got_v[i] !== exp_v[i] || got_a[i] !== 32'h100 + i || got_q[i] !== cq || start_cyc[i] != 2 + i) begin
                errors++;
                $display("FAIL f2x2_ray%0d: got v=%h a=%h q=%h cyc=%0d expected v=%h a=%h q=%h cyc=%0d",
                         i, got_v[i], got_a[i], got_q[i], start_cyc[i], exp_v[i], 32'h100 + i, cq, 2 + i);
            end
        end
        checks++;
        if (flush_first != 1 || flush_cnt != 1) begin
            errors++; $display("FAIL f2x2_flush: got first=%0d cnt=%0d expected 1/1", flush_first, flush_cnt);
        end
        checks++;
        if (busy_at0 != 0 || busy_at1 != 1 || busy_gap != 0 || busy_after_done != 0) begin
            errors++; $display("FAIL f2x2_busy: got c0=%0d c1=%0d gap=%0d after=%0d expected 0/1/0/0",
                               busy_at0, busy_at1, busy_gap, busy_after_done);
        end
        checks++;
        if (done_cyc != model_done(5, 2) || done_cnt != 1 || timed_out != 0) begin
            errors++; $display("FAIL f2x2_done: got cyc=%0d cnt=%0d to=%0d expected cyc=%0d cnt=1",
                               done_cyc, done_cnt, timed_out, model_done(5, 2));
        end
    endtask

    task automatic test_ready_toggle();
        vec_t cv, stx, sty;
        logic [AW-1:0] b;
        cv = rand_vec(); stx = rand_vec(); sty = rand_vec(); b = $urandom();
        run_frame(3, 1, b, rand_vec(), cv, stx, sty, 1, 0, -1, 0, 200);
        checks++;
        if (got_v.size() != 3 || noready_starts != 0 || hold_err != 0) begin
            errors++; $display("FAIL toggle_handshake: got starts=%0d noready=%0d hold=%0d expected 3/0/0",
                               got_v.size(), noready_starts, hold_err);
        end
        for (int i = 0; i < got_v.size(); i++) begin
            checks++;
            if (got_v[i] !== model_v(cv, stx, sty, i, 0) || got_a[i] !== model_a(b, 3, i, 0)) begin
                errors++; $display("FAIL toggle_ray%0d: got v=%h a=%h expected v=%h a=%h", i, got_v[i],
                                   got_a[i], model_v(cv, stx, sty, i, 0), model_a(b, 3, i, 0));
            end
        end
        checks++;
        if (start_cyc.size() == 0 || done_cyc != model_done(start_cyc[start_cyc.size()-1], 0)) begin
            errors++; $display("FAIL toggle_done: got cyc=%0d", done_cyc);
        end
    endtask

    task automatic test_zero_width();
        run_frame(0, 3, $urandom(), rand_vec(), rand_vec(), rand_vec(), rand_vec(), 0, 0, -1, 0, 100);
        checks++;
        if (flush_cnt != 1 || flush_first != 1 || got_v.size() != 0) begin
            errors++; $display("FAIL zero_flush: got flush=%0d@%0d starts=%0d expected 1@1 starts=0",
                               flush_cnt, flush_first, got_v.size());
        end
        checks++;
        if (done_cyc != 4 || done_cnt != 1) begin
            errors++; $display("FAIL zero_done: got cyc=%0d cnt=%0d expected 4/1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_x[3];
        exp_x[0] = 16'h0000; exp_x[1] = 16'hFFFF; exp_x[2] = 16'hFFFE;
        run_frame(3, 1, $urandom(), rand_vec(), '0, {16'd0, 16'd0, 16'hFFFF}, rand_vec(), 0, 0, -1, 0, 100);
        checks++;
        if (got_v.size() != 3) begin
            errors++; $display("FAIL wrap_count: got %0d expected 3", got_v.size());
        end
        for (int i = 0; i < got_v.size() && i < 3; i++) begin
            checks++;
            if (got_v[i][0] !== exp_x[i] || got_v[i][2:1] !== '0) begin
                errors++; $display("FAIL wrap_x%0d: got %h expected %h", i, got_v[i], {32'd0, exp_x[i]});
            end
        end
    endtask

    task automatic test_busy_hold();
        run_frame(2, 3, $urandom(), rand_vec(), rand_vec(), rand_vec(), rand_vec(), 0, 20, -1, 1, 300);
        checks++;
        if (got_v.size() != 6 || flush_cnt != 1) begin
            errors++; $display("FAIL hold_ignore: got starts=%0d flush=%0d expected 6/1", got_v.size(), flush_cnt);
        end
        checks++;
        if (start_cyc.size() == 0 || done_cyc != model_done(start_cyc[start_cyc.size()-1], 20) ||
            done_cnt != 1 || busy_after_done != 0) begin
            errors++; $display("FAIL hold_done: got cyc=%0d cnt=%0d busy_after=%0d", done_cyc, done_cnt, busy_after_done);
        end
    endtask

    task automatic test_reset_midframe();
        vec_t cv, stx, sty;
        logic [AW-1:0] b;
        int bad;
        cv = rand_vec(); stx = rand_vec(); sty = rand_vec(); b = $urandom();
        run_frame(4, 4, b, rand_vec(), cv, stx, sty, 0, 0, 5, 0, 200);
        checks++;
        if (rst_snap_ok != 1 || post_rst_starts != 0 || done_cnt != 0 || got_v.size() != 5) begin
            errors++; $display("FAIL abort: got snap=%0d post=%0d done=%0d starts=%0d expected 1/0/0/5",
                               rst_snap_ok, post_rst_starts, done_cnt, got_v.size());
        end
        cv = rand_vec(); stx = rand_vec(); sty = rand_vec(); b = $urandom();
        run_frame(4, 4, b, rand_vec(), cv, stx, sty, 0, 1, -1, 0, 200);
        bad = 0;
        for (int i = 0; i < got_v.size(); i++)
            if (got_v[i] !== model_v(cv, stx, sty, i % 4, i / 4) || got_a[i] !== model_a(b, 4, i % 4, i / 4)) bad++;
        checks++;
        if (got_v.size() != 16 || bad != 0 || done_cnt != 1) begin
            errors++; $display("FAIL after_abort: got starts=%0d bad=%0d done=%0d expected 16/0/1",
                               got_v.size(), bad, done_cnt);
        end
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 5; t++) begin
            vec_t cq, cv, stx, sty;
            logic [AW-1:0] b;
            int w, h, hold, bad;
            w = $urandom_range(1, 6); h = $urandom_range(1, 4); hold = $urandom_range(0, 4);
            cq = rand_vec(); cv = rand_vec(); stx = rand_vec(); sty = rand_vec(); b = $urandom();
            run_frame(w, h, b, cq, cv, stx, sty, 2, hold, -1, 0, 400);
            bad = 0;
            for (int i = 0; i < got_v.size(); i++)
                if (got_v[i] !== model_v(cv, stx, sty, i % w, i / w) ||
                    got_a[i] !== model_a(b, w, i % w, i / w) || got_q[i] !== cq) bad++;
            checks++;
            if (got_v.size() != w * h || bad != 0 || noready_starts != 0 || hold_err != 0) begin
                errors++; $display("FAIL rand%0d_rays: %0dx%0d got starts=%0d bad=%0d noready=%0d hold=%0d",
                                   t, w, h, got_v.size(), bad, noready_starts, hold_err);
            end
            checks++;
            if (start_cyc.size() == 0 || done_cyc != model_done(start_cyc[start_cyc.size()-1], hold) || timed_out != 0) begin
                errors++; $display("FAIL rand%0d_done: got cyc=%0d timeout=%0d", t, done_cyc, timed_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_2x2();
        test_ready_toggle();
        test_zero_width();
        test_wrap();
        test_busy_hold();
        test_reset_midframe();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
